imgmem_fill_ctrl: RTL and testbench



---
 rtl/imgfill_pkg.sv | 32 +++
 rtl/rect_addr_gen.sv | 62 ++++++
 rtl/imgmem_fill_ctrl.sv | 146 ++++++++++++++
 tb/tb_imgmem_fill_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imgfill_pkg.sv
// imgfill_pkg: shared constants, the fill-controller state enum and the
// rectangle bounds check. The bounds check is used by both the controller
// and the bench, so the two always agree on which requests are rejected.
package imgfill_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } fill_state_t;

  // A rectangle is accepted only if it is non-empty and lies fully on screen.
  // The sums are formed at integer width, so x0+w and y0+h cannot wrap.
  function automatic logic rect_in_bounds(
    input logic [9:0] x0,
    input logic [8:0] y0,
    input logic [9:0] w,
    input logic [8:0] h,
    input int         sw,
    input int         sh
  );
    return (w != 10'd0) && (h != 9'd0) &&
           ((int'(x0) + int'(w)) <= sw) &&
           ((int'(y0) + int'(h)) <= sh);
  endfunction

endpackage

// File: rtl/rect_addr_gen.sv
// rect_addr_gen: walks a rectangle row by row and produces the image RAM
// address of the current pixel.
//   clock, reset : clock and synchronous active-high reset
//   load         : capture x0/y0/w/h and point at the top-left pixel
//   advance      : step to the next pixel (row-major order)
//   x0, y0, w, h : rectangle origin and size (must already be in bounds)
//   addr         : address of the current pixel, y*SCREEN_W + x
//   last         : current pixel is the bottom-right corner
module rect_addr_gen #(
  parameter int SCREEN_W = 640,
  parameter int ADDR_W   = 19
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [9:0]        x0,
  input  logic [8:0]        y0,
  input  logic [9:0]        w,
  input  logic [8:0]        h,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [9:0]        x_start_reg;
  logic [9:0]        x_end_reg;
  logic [8:0]        y_end_reg;
  logic [9:0]        cur_x_reg;
  logic [8:0]        cur_y_reg;
  logic [ADDR_W-1:0] row_base_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      x_start_reg  <= '0;
      x_end_reg    <= '0;
      y_end_reg    <= '0;
      cur_x_reg    <= '0;
      cur_y_reg    <= '0;
      row_base_reg <= '0;
    end else if (load) begin
      x_start_reg  <= x0;
      x_end_reg    <= x0 + w - 10'd1;
      y_end_reg    <= h - 9'd1;
      cur_x_reg    <= x0;
      cur_y_reg    <= '0;
      // The only multiply: done once per fill, never per pixel.
      row_base_reg <= ADDR_W'(y0) * ADDR_W'(SCREEN_W);
    end else if (advance) begin
      if (cur_x_reg == x_end_reg) begin
        cur_x_reg    <= x_start_reg;
        cur_y_reg    <= cur_y_reg + 9'd1;
        row_base_reg <= row_base_reg + ADDR_W'(SCREEN_W);
      end else begin
        cur_x_reg <= cur_x_reg + 10'd1;
      end
    end
  end

  assign addr = row_base_reg + ADDR_W'(cur_x_reg);
  assign last = (cur_x_reg == x_end_reg) && (cur_y_reg == y_end_reg);

endmodule

// File: rtl/imgmem_fill_ctrl.sv
// imgmem_fill_ctrl: rectangle-fill engine and image RAM port-A arbiter.
// The processor always owns the port when cpu_req is high (combinational
// pass-through); the fill engine writes one pixel in each idle cycle.
//   clock, reset          : clock, synchronous active-high reset
//   start,x0,y0,w,h,color : fill request (sampled in IDLE only)
//   abort                 : cancel an in-progress fill
//   cpu_req/addr/data/wren: processor side of the port
//   mem_addr/data/wren    : to imgram port A
//   busy, done, err       : status; done and err are one-cycle pulses
//   stall_cycles          : FILL cycles lost to the processor
// Build option: define IMGFILL_PERF_CNT_EN to build the stall counter;
// otherwise stall_cycles is tied to zero.
module imgmem_fill_ctrl #(
  parameter int SCREEN_W = imgfill_pkg::SCREEN_W,
  parameter int SCREEN_H = imgfill_pkg::SCREEN_H,
  parameter int ADDR_W   = imgfill_pkg::ADDR_W,
  parameter int DATA_W   = imgfill_pkg::DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [9:0]        x0,
  input  logic [8:0]        y0,
  input  logic [9:0]        w,
  input  logic [8:0]        h,
  input  logic [DATA_W-1:0] color,
  input  logic              abort,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              cpu_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       stall_cycles
);
  import imgfill_pkg::*;

  fill_state_t       state_reg, state_next;
  logic [DATA_W-1:0] color_reg;
  logic              err_reg, err_next;
  logic              req_ok;
  logic              load;
  logic              advance;
  logic              last;
  logic [ADDR_W-1:0] fill_addr;

  assign req_ok = rect_in_bounds(x0, y0, w, h, SCREEN_W, SCREEN_H);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
      err_reg   <= 1'b0;
      color_reg <= '0;
    end else begin
      state_reg <= state_next;
      err_reg   <= err_next;
      if (load) color_reg <= color;
    end
  end

  always_comb begin
    state_next = state_reg;
    err_next   = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (req_ok) begin
            load       = 1'b1;
            state_next = FILL;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      FILL: begin
        // The pixel for this cycle is still written when abort is high;
        // abort only stops the engine from continuing.
        advance = !cpu_req;
        if (abort)
          state_next = IDLE;
        else if (advance && last)
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  rect_addr_gen #(
    .SCREEN_W(SCREEN_W),
    .ADDR_W  (ADDR_W)
  ) u_addr_gen (
    .clock  (clock),
    .reset  (reset),
    .load   (load),
    .advance(advance),
    .x0     (x0),
    .y0     (y0),
    .w      (w),
    .h      (h),
    .addr   (fill_addr),
    .last   (last)
  );

  // Port mux: processor first, then the fill engine, otherwise a quiet port.
  always_comb begin
    mem_addr = cpu_addr;
    mem_data = cpu_data;
    mem_wren = 1'b0;
    if (cpu_req) begin
      mem_wren = cpu_wren;
    end else if (state_reg == FILL) begin
      mem_addr = fill_addr;
      mem_data = color_reg;
      mem_wren = 1'b1;
    end
  end

  assign busy = (state_reg == FILL) || (state_reg == DONE);
  assign done = (state_reg == DONE);
  assign err  = err_reg;

`ifdef IMGFILL_PERF_CNT_EN
  logic [15:0] stall_reg;

  always_ff @(posedge clock) begin
    if (reset)
      stall_reg <= '0;
    else if (load)
      stall_reg <= '0;
    else if ((state_reg == FILL) && cpu_req && (stall_reg != 16'hFFFF))
      stall_reg <= stall_reg + 16'd1;
  end

  assign stall_cycles = stall_reg;
`else
  assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_imgmem_fill_ctrl.sv
// tb_imgmem_fill_ctrl: directed bench for imgmem_fill_ctrl. A queue-based
// model predicts every port-A cycle; literal expectations from the test
// plan pin fill addresses, completion latency and error behaviour.
module tb_imgmem_fill_ctrl;
  import imgfill_pkg::*;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [9:0]        x0 = '0;
  logic [8:0]        y0 = '0;
  logic [9:0]        w = '0;
  logic [8:0]        h = '0;
  logic [DATA_W-1:0] color = '0;
  logic              abort = 1'b0;
  logic              cpu_req = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_data = '0;
  logic              cpu_wren = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic              busy, done, err;
  logic [15:0]       stall_cycles;

  imgmem_fill_ctrl dut (
    .clock(clock), .reset(reset), .start(start),
    .x0(x0), .y0(y0), .w(w), .h(h), .color(color), .abort(abort),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_wren(cpu_wren),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren),
    .busy(busy), .done(done), .err(err), .stall_cycles(stall_cycles)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_start = 0;
  bit chk_en = 1'b0;

  // Model: 0 idle, 1 filling, 2 done. Pending pixel addresses in a queue.
  int          m_phase = 0;
  int          m_q[$];
  logic [7:0]  m_color = '0;
  bit          m_err = 1'b0;
  int          m_stall = 0;

  // Observation log for the directed checks.
  int wlog[$];
  int done_cyc = -1;
  int err_cyc = -1;
  bit busy_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  // Model update on every active edge, using the inputs held before it.
  initial forever begin
    @(posedge clock);
    cyc = cyc + 1;
    if (reset) begin
      m_phase = 0; m_q.delete(); m_err = 0; m_stall = 0;
    end else begin
      m_err = 0;
      case (m_phase)
        0: if (start) begin
          if (rect_in_bounds(x0, y0, w, h, SCREEN_W, SCREEN_H)) begin
            m_q.delete();
            for (int yy = 0; yy < int'(h); yy++)
              for (int xx = 0; xx < int'(w); xx++)
                m_q.push_back((int'(y0) + yy) * SCREEN_W + int'(x0) + xx);
            m_color = color; m_stall = 0; m_phase = 1;
          end else begin
            m_err = 1;
          end
        end
        1: begin
          if (cpu_req && m_stall < 65535) m_stall++;
          if (abort) begin
            m_phase = 0; m_q.delete();
          end else if (!cpu_req) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial forever begin
    logic              e_fill, e_wren;
    logic [ADDR_W-1:0] e_addr;
    logic [7:0]        e_data;
    int                e_stall;
    @(negedge clock);
    if (chk_en) begin
      e_fill = (m_phase == 1) && (m_q.size() > 0);
      e_wren = cpu_req ? cpu_wren : e_fill;
      e_addr = cpu_req ? cpu_addr : (e_fill ? ADDR_W'(m_q[0]) : cpu_addr);
      e_data = cpu_req ? cpu_data : (e_fill ? m_color : cpu_data);
`ifdef IMGFILL_PERF_CNT_EN
      e_stall = m_stall;
`else
      e_stall = 0;
`endif
      chk("mem_wren", 32'(mem_wren), 32'(e_wren));
      if (e_wren) begin
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_data", 32'(mem_data), 32'(e_data));
      end
      chk("busy", 32'(busy), 32'(m_phase != 0));
      chk("done", 32'(done), 32'(m_phase == 2));
      chk("err", 32'(err), 32'(m_err));
      chk("stall_cycles", 32'(stall_cycles), 32'(e_stall));
      if (!cpu_req && mem_wren) wlog.push_back(int'(mem_addr));
      if (done) done_cyc = cyc;
      if (err) err_cyc = cyc;
      if (busy) busy_seen = 1'b1;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // Presents a request for one edge; afterwards the bench is in cycle t+1.
  task automatic do_start(input int ax, input int ay, input int aw, input int ah, input int ac);
    wlog.delete(); done_cyc = -1; err_cyc = -1; busy_seen = 1'b0;
    x0 = 10'(ax); y0 = 9'(ay); w = 10'(aw); h = 9'(ah); color = 8'(ac);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    t_start = cyc;
  endtask

  function automatic int rel(input int c);
    return (c < 0) ? -1 : c - t_start + 1;
  endfunction

  task automatic report(input string name);
    $display("txn %s: writes=%0d done_at=t+%0d err_at=t+%0d", name, wlog.size(), rel(done_cyc), rel(err_cyc));
  endtask

  task automatic check_basic_writes(input string tag);
    int exp_a[6] = '{12810, 12811, 12812, 13450, 13451, 13452};
    chk({tag, "_nwrites"}, 32'(wlog.size()), 32'd6);
    if (wlog.size() == 6)
      for (int i = 0; i < 6; i++) chk({tag, "_addr"}, 32'(wlog[i]), 32'(exp_a[i]));
  endtask

  task automatic run_basic(input string tag);
    do_start(10, 20, 3, 2, 'h1C);
    wait_cycles(10);
    report(tag);
    check_basic_writes(tag);
    chk({tag, "_done_t"}, 32'(rel(done_cyc)), 32'd7);
  endtask

  initial begin
    @(posedge clock);
    #1;
    chk_en = 1'b1;
    wait_cycles(2);
    reset = 1'b0;
    wait_cycles(1);

    // Plain 3x2 fill.
    run_basic("basic");

    // Same fill with the processor taking cycles t+2..t+4.
    do_start(10, 20, 3, 2, 'h1C);
    wait_cycles(1);
    cpu_req = 1'b1; cpu_addr = 19'd500; cpu_wren = 1'b1; cpu_data = 8'hA5;
    wait_cycles(3);
    cpu_req = 1'b0; cpu_wren = 1'b0;
    wait_cycles(10);
    report("contended");
    check_basic_writes("contended");
    chk("contended_done_t", 32'(rel(done_cyc)), 32'd10);
`ifdef IMGFILL_PERF_CNT_EN
    chk("contended_stall", 32'(stall_cycles), 32'd3);
`endif

    // Rejected requests.
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: do_start(630, 0, 11, 1, 'h11);
        1: do_start(5, 5, 0, 3, 'h22);
        default: do_start(0, 479, 4, 2, 'h33);
      endcase
      wait_cycles(4);
      report("reject");
      chk("reject_err_t", 32'(rel(err_cyc)), 32'd1);
      chk("reject_nwrites", 32'(wlog.size()), 32'd0);
      chk("reject_busy", 32'(busy_seen), 32'd0);
    end

    // Single bottom-right pixel.
    do_start(639, 479, 1, 1, 'h7F);
    wait_cycles(5);
    report("corner");
    chk("corner_nwrites", 32'(wlog.size()), 32'd1);
    if (wlog.size() == 1) chk("corner_addr", 32'(wlog[0]), 32'd307199);
    chk("corner_done_t", 32'(rel(done_cyc)), 32'd2);

    // 40x20 fill aborted in cycle t+100.
    do_start(5, 10, 40, 20, 'h3C);
    wait_cycles(99);
    abort = 1'b1;
    wait_cycles(1);
    abort = 1'b0;
    report("abort");
    chk("abort_nwrites", 32'(wlog.size()), 32'd100);
    if (wlog.size() == 100) chk("abort_last_addr", 32'(wlog[99]), 32'd7704);
    chk("abort_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
    do_start(0, 0, 2, 1, 'h01);
    wait_cycles(5);
    report("after_abort");
    chk("after_abort_nwrites", 32'(wlog.size()), 32'd2);
    chk("after_abort_done_t", 32'(rel(done_cyc)), 32'd3);

    // Reset in cycle t+5 of the 3x2 fill, then the 3x2 fill again.
    do_start(10, 20, 3, 2, 'h1C);
    wait_cycles(4);
    reset = 1'b1;
    wait_cycles(1);
    reset = 1'b0;
    wait_cycles(4);
    report("reset_mid");
    chk("reset_no_done", 32'(done_cyc), 32'hFFFF_FFFF);
    chk("reset_nwrites", 32'(wlog.size()), 32'd5);
    run_basic("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
